mash_mmd_ctrl: RTL
==================

# mash_mmd_ctrl

Programmable multi-modulus divider control stage that sits directly downstream of `hk_mash111`. It consumes the modulator's signed `y_o` stream, adds it to an integer divide ratio, and counts the instantaneous ratio out on `clk`. It emits one `div_o` pulse per division period, with a matching `req_o` strobe marking the cycle in which the next `y_i` was consumed. The long-run average period is `n_int_i` plus the modulator's fractional mean, which makes this the fractional-N divider core of the DDSM chain.

## Interface

Parameters:
- `NINT_W`, default 8: width of the integer ratio input.
- `Y_W`, default 4: width of the signed MASH output (matches `hk_mash111` `y_o`).
- `CNT_W`, default 9: width of the period counter and of `ratio_o`; the maximum ratio is 2^CNT_W-1.
- `MIN_RATIO`, default 4: lowest applied ratio. Legal range is 2 to 2^CNT_W-1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `en_i`, in, 1: run enable.
- `n_int_i`, in, `NINT_W`: unsigned integer ratio N.
- `y_i`, in, `Y_W`: signed two's-complement MASH correction (HK-MASH111 range is -3..+4).
- `div_o`, out, 1: one-cycle pulse at the end of each division period.
- `req_o`, out, 1: one-cycle pulse asserted the cycle after `y_i`/`n_int_i` were sampled.
- `ratio_o`, out, `CNT_W`: ratio applied to the period now being counted.
- `err_o`, out, 1: sticky flag, set when a ratio was clamped.

## Operation

- States: IDLE and RUN. The state is held in a register.
- Ratio computation, combinational:
  - sum = zero-extended `n_int_i` + sign-extended `y_i`, computed in CNT_W+2 signed bits.
  - If sum < `MIN_RATIO`, ratio = `MIN_RATIO` and clamp = 1.
  - If sum > 2^CNT_W-1, ratio = 2^CNT_W-1 and clamp = 1.
  - Otherwise ratio = sum and clamp = 0.
- IDLE:
  - `cnt` = 0; `div_o` = `req_o` = 0.
  - On an edge with `en_i` = 1: load `cnt` with ratio-1, load `ratio_o` with ratio, set `req_o` to 1, move to RUN. `div_o` stays 0 on this edge.
- RUN, `en_i` = 1, `cnt` != 0: decrement `cnt`; `div_o` = `req_o` = 0.
- RUN, `en_i` = 1, `cnt` = 0 (terminal edge):
  - Reload `cnt` with ratio-1 from the inputs present at this edge.
  - Load `ratio_o`, set `div_o` = 1 and `req_o` = 1 for exactly one cycle.
- RUN, `en_i` = 0 (any edge, including the terminal edge): go to IDLE immediately. Clear `cnt`, `div_o` and `req_o`; `ratio_o` holds its value. There is no `div_o` pulse on abort.
- `err_o`: set on any loading edge (IDLE start or terminal) where clamp = 1. It is cleared only by `rst_n`.
- Inputs `n_int_i` and `y_i` are sampled only on loading edges. They are don't-care at all other edges.

## Timing

- Reset values: state = IDLE, `cnt` = 0, `div_o` = 0, `req_o` = 0, `ratio_o` = 0, `err_o` = 0. Reset is applied asynchronously and released synchronously by the bench.
- Start latency: if `en_i` is first seen high at edge E0, `req_o` is high during E0..E1. The first `div_o` pulse follows edge E0+R0, where R0 is the ratio sampled at E0.
- Steady state: consecutive `div_o` rising edges are exactly ratio_k cycles apart, where ratio_k is the ratio sampled at the preceding terminal edge.
- `req_o` coincides with every `div_o` pulse and also with the start pulse. An upstream modulator that advances on `req_o` presents the next `y_i` at least one cycle before the next terminal edge. This always holds because ratio is at least 2.
- Simultaneous events:
  - `en_i` falling on the terminal edge: abort wins, and `div_o` is not pulsed.
  - Clamp and terminal on the same edge: the reload uses the clamped value and `err_o` rises on that same edge.
- Reset asserted mid-period: all outputs are forced to their reset values immediately, independent of `clk`.

## Test plan

- Reset and idle: hold `rst_n` = 0 for 2 cycles, then keep `en_i` = 0 for 20 cycles. Required: `div_o`, `req_o`, `ratio_o` and `err_o` stay 0 throughout.
- Constant ratio: `n_int_i` = 10, `y_i` = 0, `en_i` = 1 from E0. Required:
  - `req_o` pulses after E0.
  - `div_o` pulses after E10, E20 and E30.
  - `ratio_o` = 10 throughout.
- Correction sequence: `n_int_i` = 10, and `y_i` advances on each `req_o` through +4, -3, +1, 0. Required: the spacing between `div_o` pulses is 14, 7, 11, 10 cycles, and `ratio_o` tracks those values.
- Clamping:
  - `n_int_i` = 2, `y_i` = -3. Required: period 4 (`MIN_RATIO`) and `err_o` = 1 from the start edge.
  - `n_int_i` = 255, `y_i` = +4 with `CNT_W` = 8. Required: period 255 and `err_o` = 1.
- Abort: `n_int_i` = 20, y = 0. Drop `en_i` at cycle 7 of a period, then re-raise it 3 cycles later. Required:
  - No `div_o` pulse on the abort.
  - State returns to IDLE.
  - After re-enable, a fresh full 20-cycle period runs.
- Closed loop with `hk_mash111` (`WIDTH` = 9, `A_GAIN` = 2, `x_i` = 16), advanced on `req_o`, with `n_int_i` = 20. Required:
  - Over 1024 `div_o` periods, the total cycle count is 20×1024 + 32, within ±4.
  - Every period lies within 17..24.
  - `err_o` stays 0.

Source files
------------

// File: rtl/mash_mmd_ctrl.sv
// Fractional-N multi-modulus divider control: counts out n_int_i + y_i cycles per
// period and pulses div_o/req_o on each load, with the applied ratio clamped to range.
module mash_mmd_ctrl #(
  parameter int NINT_W    = 8,
  parameter int Y_W       = 4,
  parameter int CNT_W     = 9,
  parameter int MIN_RATIO = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [NINT_W-1:0] n_int_i,
  input  logic [Y_W-1:0]    y_i,
  output logic              div_o,
  output logic              req_o,
  output logic [CNT_W-1:0]  ratio_o,
  output logic              err_o
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam int SUM_W = CNT_W + 2;
  localparam logic signed [SUM_W-1:0] MIN_S = SUM_W'(MIN_RATIO);
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'((2 ** CNT_W) - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   ratio_q, ratio_d;
  logic               div_q, div_d;
  logic               req_q, req_d;
  logic               err_q, err_d;

  logic signed [SUM_W-1:0] sum;
  logic [CNT_W-1:0]        ratio;
  logic                    clamp;
  logic                    load;

  // n_int_i is unsigned and y_i is two's complement; widen each accordingly before adding.
  always_comb begin
    sum   = signed'(SUM_W'(n_int_i)) + SUM_W'($signed(y_i));
    ratio = sum[CNT_W-1:0];
    clamp = 1'b0;
    if (sum < MIN_S) begin
      ratio = CNT_W'(MIN_RATIO);
      clamp = 1'b1;
    end else if (sum > MAX_S) begin
      ratio = '1;
      clamp = 1'b1;
    end
  end

  always_comb begin
    // NOTE: every signal is given a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    err_d   = err_q;
    div_d   = 1'b0;
    req_d   = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en_i) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!en_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          load  = 1'b1;
          div_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Start and terminal edges share one load path; abort never reaches it.
    if (load) begin
      cnt_d   = ratio - CNT_W'(1);
      ratio_d = ratio;
      req_d   = 1'b1;
      if (clamp) err_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ratio_q <= '0;
      div_q   <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
      div_q   <= div_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  assign div_o   = div_q;
  assign req_o   = req_q;
  assign ratio_o = ratio_q;
  assign err_o   = err_q;

endmodule
